// File: rtl/calc_pkg.sv
// Shared character codes, FSM state encoding and key-map helpers for the
// keypad expression writer.
package calc_pkg;

  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_HASH   = 8'h23;

  typedef enum logic [2:0] {
    ST_SCAN      = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_WRITE     = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RELEASE   = 3'd5
  } state_t;

  // Column 3 holds the operators, row 3 the parentheses; the rest is a 3x3 digit grid.
  function automatic logic [7:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] code;
    code = CH_0;
    if (col == 2'd3) begin
      case (row)
        2'd0:    code = CH_PLUS;
        2'd1:    code = CH_MINUS;
        2'd2:    code = CH_STAR;
        default: code = CH_HASH;
      endcase
    end else if (row == 2'd3) begin
      case (col)
        2'd0:    code = CH_LPAREN;
        2'd1:    code = CH_0;
        default: code = CH_RPAREN;
      endcase
    end else begin
      code = CH_0 + 8'd1 + 8'd3 * {6'd0, row} + {6'd0, col};
    end
    return code;
  endfunction

  function automatic logic is_terminator(input logic [7:0] code);
    return code == CH_HASH;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Keypad row rotation, column synchronizer and single-key detection.
// While hold is high the current row stays driven so the caller can debounce it.
module keypad_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_col,
  input  logic       hold,
  output logic [3:0] kp_row,
  output logic [3:0] col_sync,
  output logic       key_valid,
  output logic [1:0] row_idx,
  output logic [1:0] col_idx
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]    r_col_meta;
  logic [3:0]    r_col_sync;
  logic [DW-1:0] r_div;
  logic [1:0]    r_row_idx;
  logic          w_last;
  logic          w_single;
  logic [1:0]    w_col_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_single  = 1'b0;
    w_col_idx = 2'd0;
    case (r_col_sync)
      4'b1110: begin w_single = 1'b1; w_col_idx = 2'd0; end
      4'b1101: begin w_single = 1'b1; w_col_idx = 2'd1; end
      4'b1011: begin w_single = 1'b1; w_col_idx = 2'd2; end
      4'b0111: begin w_single = 1'b1; w_col_idx = 2'd3; end
      default: ;
    endcase
  end

  assign w_last    = (r_div == DW'(SCAN_DIV - 1));
  assign key_valid = !hold && w_last && w_single;
  assign row_idx   = r_row_idx;
  assign col_idx   = w_col_idx;
  assign col_sync  = r_col_sync;
  assign kp_row    = ~(4'b0001 << r_row_idx);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_div      <= '0;
      r_row_idx  <= 2'd0;
    end else begin
      r_col_meta <= kp_col;
      r_col_sync <= r_col_meta;
      if (hold) begin
        r_div <= '0;
      end else if (w_last) begin
        r_div <= '0;
        // A detected key keeps its row so the debouncer sees the same row next.
        if (!w_single) r_row_idx <= r_row_idx + 2'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_expr_writer.sv
// Debounces keypad presses and writes their character codes into the
// expression buffer; '#' terminates and triggers evaluation.
// Optional KEYPAD_ECHO_EN adds last_key, the most recently written code.
module keypad_expr_writer
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int MAX_LEN      = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_col,
  output logic [3:0] kp_row,
  input  logic       done,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       start,
  output logic       busy,
  output logic       overflow
`ifdef KEYPAD_ECHO_EN
  ,
  output logic [7:0] last_key
`endif
);

  localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]      PTR_FULL = 8'(MAX_LEN - 1);

  state_t        r_state;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_ptr;
  logic          r_mem_we;
  logic [7:0]    r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_start;
  logic          r_busy;
  logic          r_overflow;

  logic          w_key_valid;
  logic [1:0]    w_row_idx;
  logic [1:0]    w_col_idx;
  logic [3:0]    w_col_sync;
  logic [3:0]    w_expect;
  logic [7:0]    w_code;
  logic          w_is_hash;
  logic          w_full;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .kp_col    (kp_col),
    .hold      (r_state != ST_SCAN),
    .kp_row    (kp_row),
    .col_sync  (w_col_sync),
    .key_valid (w_key_valid),
    .row_idx   (w_row_idx),
    .col_idx   (w_col_idx)
  );

  assign w_code    = key_code(r_row, r_col);
  assign w_expect  = ~(4'b0001 << r_col);
  assign w_is_hash = is_terminator(w_code);
  assign w_full    = (r_ptr == PTR_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      r_cnt       <= '0;
      r_ptr       <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'd0;
      r_mem_wdata <= 8'd0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_start  <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_key_valid) begin
            r_row   <= w_row_idx;
            r_col   <= w_col_idx;
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_col_sync != w_expect) begin
            r_state <= ST_SCAN;
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end else if (w_full && !w_is_hash) begin
            // Last slot is reserved for the terminator.
            r_overflow <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_RELEASE;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= w_code;
            if (w_is_hash) r_busy <= 1'b1;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_ptr <= r_ptr + 8'd1;
          r_cnt <= '0;
          if (w_is_hash) begin
            r_start <= 1'b1;
            r_state <= ST_START;
          end else begin
            r_state <= ST_RELEASE;
          end
        end
        ST_START: r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (done) begin
            r_ptr      <= 8'd0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_col_sync != 4'hF)   r_cnt   <= '0;
          else if (r_cnt == CNT_LAST) r_state <= ST_SCAN;
          else                      r_cnt   <= r_cnt + CW'(1);
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign start     = r_start;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

`ifdef KEYPAD_ECHO_EN
  logic [7:0] r_last_key;

  always_ff @(posedge clk) begin
    if (rst)                                    r_last_key <= 8'h00;
    else if (r_state == ST_DEBOUNCE && w_col_sync == w_expect &&
             r_cnt == CNT_LAST && !(w_full && !w_is_hash)) r_last_key <= w_code;
  end

  assign last_key = r_last_key;
`endif

endmodule
